display_scan_ctrl: RTL and testbench

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

---
 rtl/display_scan_ctrl.sv | 171 +++++++++++++++++
 tb/tb_display_scan_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// Multiplexed display scanner: steps through NUM_DIGITS digits with a dead
// gap between them, double-buffers the digit data so a frame never tears,
// and applies per-digit blanking and leading-zero suppression.
module display_scan_ctrl #(
  parameter int NUM_DIGITS    = 8,
  parameter int REFRESH_DIV   = 100000,
  parameter int DEAD_CYCLES   = 16,
  parameter int AN_ACTIVE_LOW = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [4*NUM_DIGITS-1:0]       data_in,
  input  logic                          load,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic [NUM_DIGITS-1:0]         blank_mask,
  input  logic                          lz_en,
  output logic [NUM_DIGITS-1:0]         anode,
  output logic [3:0]                    nibble,
  output logic                          dp,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_tick
);

  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int CNT_MAX = (REFRESH_DIV > DEAD_CYCLES) ? REFRESH_DIV : DEAD_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0]      DRV_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0]      DEAD_LAST = CNT_W'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  // Anode vector with every digit disabled, in the configured polarity.
  localparam logic [NUM_DIGITS-1:0] AN_OFF    = {NUM_DIGITS{AN_ACTIVE_LOW != 0}};

  typedef enum logic {S_DRIVE, S_DEAD} state_e;

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [IDX_W-1:0]        idx_q;

  logic [4*NUM_DIGITS-1:0] pend_q, shad_q;
  logic [NUM_DIGITS-1:0]   pend_dp_q, shad_dp_q;
  logic                    pend_flag_q;
  logic                    slot_blank_q;

  logic [IDX_W-1:0]        idx_nxt;
  logic                    adv, wrap, xfer;
  logic [NUM_DIGITS-1:0]   lz_cand;
  logic                    blank_now, blank_eff;
  logic [NUM_DIGITS-1:0]   sel_oh;

  // Scan advance / frame wrap detection; the wrap to digit 0 is the only
  // point where the shadow may change, so a frame is always consistent.
  always_comb begin
    idx_nxt = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    adv     = ((state_q == S_DRIVE) && (cnt_q == DRV_LAST) && (DEAD_CYCLES == 0)) ||
              ((state_q == S_DEAD)  && (cnt_q == DEAD_LAST));
    wrap    = adv && (idx_q == IDX_LAST);
    xfer    = wrap && pend_flag_q;
  end

  // Scan FSM: DRIVE for REFRESH_DIV cycles, then DEAD (skipped when zero).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_DRIVE;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        S_DRIVE: begin
          if (cnt_q == DRV_LAST) begin
            cnt_q <= '0;
            if (DEAD_CYCLES == 0) idx_q   <= idx_nxt;
            else                  state_q <= S_DEAD;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DEAD: begin
          if (cnt_q == DEAD_LAST) begin
            cnt_q   <= '0;
            state_q <= S_DRIVE;
            idx_q   <= idx_nxt;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= S_DRIVE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Pending/shadow double buffer. A load on the transfer edge lands in
  // pending while the shadow takes the older pending value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q      <= '0;
      pend_dp_q   <= '0;
      pend_flag_q <= 1'b0;
      shad_q      <= '0;
      shad_dp_q   <= '0;
    end else begin
      if (xfer) begin
        shad_q    <= pend_q;
        shad_dp_q <= pend_dp_q;
      end
      if (load) begin
        pend_q      <= data_in;
        pend_dp_q   <= dp_in;
        pend_flag_q <= 1'b1;
      end else if (xfer) begin
        pend_flag_q <= 1'b0;
      end
    end
  end

  // Leading-zero candidates: this nibble and every higher one are zero and
  // no decimal point is requested here. Digit 0 always shows.
  always_comb begin
    logic run;
    run     = 1'b1;
    lz_cand = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run        = run & (shad_q[4*i +: 4] == 4'd0);
      lz_cand[i] = run & ~shad_dp_q[i];
    end
    lz_cand[0] = 1'b0;
  end

  // Blank decision is sampled at the first cycle of a slot and held, so
  // live blank_mask / lz_en changes never cut a slot short.
  always_comb begin
    blank_now = blank_mask[idx_q] | (lz_en & lz_cand[idx_q]);
    blank_eff = (cnt_q == '0) ? blank_now : slot_blank_q;
    sel_oh    = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_q;
  end

  // Registered outputs, one cycle behind the FSM state and index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      anode        <= AN_OFF;
      nibble       <= 4'd0;
      dp           <= 1'b0;
      digit_idx    <= '0;
      frame_tick   <= 1'b0;
      slot_blank_q <= 1'b0;
    end else begin
      frame_tick <= xfer;
      digit_idx  <= idx_q;
      if (state_q == S_DRIVE) begin
        slot_blank_q <= blank_eff;
        if (blank_eff) begin
          anode  <= AN_OFF;
          nibble <= 4'd0;
          dp     <= 1'b0;
        end else begin
          anode  <= AN_OFF ^ sel_oh;
          nibble <= shad_q[4*idx_q +: 4];
          dp     <= shad_dp_q[idx_q];
        end
      end else begin
        anode  <= AN_OFF;
        nibble <= 4'd0;
        dp     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl: a table of per-cycle vectors for
// scan timing and tear-free update, then hand sequences for leading-zero
// suppression, live blanking, coincident load, async reset and a
// no-dead-time variant.
module tb_display_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] data_in = '0;
  logic        load = 1'b0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_mask = '0;
  logic        lz_en = 1'b0;

  logic [3:0]  anode, nibble, an1, nib1;
  logic        dp, ft, dp1, ft1;
  logic [1:0]  idx, idx1;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  display_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(4), .DEAD_CYCLES(2), .AN_ACTIVE_LOW(1)) dut (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .load(load), .dp_in(dp_in),
    .blank_mask(blank_mask), .lz_en(lz_en), .anode(anode), .nibble(nibble), .dp(dp),
    .digit_idx(idx), .frame_tick(ft));

  display_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(4), .DEAD_CYCLES(0), .AN_ACTIVE_LOW(1)) u_nodead (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .load(load), .dp_in(dp_in),
    .blank_mask(blank_mask), .lz_en(lz_en), .anode(an1), .nibble(nib1), .dp(dp1),
    .digit_idx(idx1), .frame_tick(ft1));

  typedef struct {
    logic        ld;
    logic [15:0] din;
    logic [3:0]  dpi;
    logic [3:0]  an;
    logic [3:0]  nib;
    logic        dpo;
    logic [1:0]  ix;
    logic        ft;
  } vec_t;

  vec_t vt[1:48];

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, k, act, exp);
    end
  endtask

  // One clock edge; inputs and sampling both happen on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_to(input int k);
    while (cyc < k) step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    cyc = 0;
  endtask

  task automatic rng(input int a, input int b, input logic [3:0] an, input logic [3:0] nib,
                     input logic d, input logic [1:0] ix);
    for (int k = a; k <= b; k++) begin
      vt[k].ld = 1'b0; vt[k].din = '0; vt[k].dpi = '0;
      vt[k].an = an; vt[k].nib = nib; vt[k].dpo = d; vt[k].ix = ix; vt[k].ft = 1'b0;
    end
  endtask

  task automatic chk_main(input int k, input logic [3:0] an, input logic [3:0] nib, input logic [1:0] ix);
    chk("anode", k, 32'(anode), 32'(an));
    chk("nibble", k, 32'(nibble), 32'(nib));
    chk("digit_idx", k, 32'(idx), 32'(ix));
  endtask

  logic [3:0] nd_an [0:3];

  initial begin
    // Entry k: inputs applied before edge k, outputs checked after edge k.
    rng( 1,  4, 4'hE, 4'h0, 1'b0, 2'd0);
    rng( 5,  6, 4'hF, 4'h0, 1'b0, 2'd0);
    rng( 7, 10, 4'hD, 4'h0, 1'b0, 2'd1);
    rng(11, 12, 4'hF, 4'h0, 1'b0, 2'd1);
    rng(13, 16, 4'hB, 4'h0, 1'b0, 2'd2);
    rng(17, 18, 4'hF, 4'h0, 1'b0, 2'd2);
    rng(19, 22, 4'h7, 4'h0, 1'b0, 2'd3);
    rng(23, 24, 4'hF, 4'h0, 1'b0, 2'd3);
    rng(25, 28, 4'hE, 4'h4, 1'b0, 2'd0);
    rng(29, 30, 4'hF, 4'h0, 1'b0, 2'd0);
    rng(31, 34, 4'hD, 4'h3, 1'b1, 2'd1);
    rng(35, 36, 4'hF, 4'h0, 1'b0, 2'd1);
    rng(37, 40, 4'hB, 4'h2, 1'b0, 2'd2);
    rng(41, 42, 4'hF, 4'h0, 1'b0, 2'd2);
    rng(43, 46, 4'h7, 4'h1, 1'b0, 2'd3);
    rng(47, 48, 4'hF, 4'h0, 1'b0, 2'd3);
    vt[8].ld = 1'b1; vt[8].din = 16'h1234; vt[8].dpi = 4'b0010;  // load mid digit-1 slot
    vt[24].ft = 1'b1;                                             // transfer on wrap edge
    nd_an[0] = 4'hE; nd_an[1] = 4'hD; nd_an[2] = 4'hB; nd_an[3] = 4'h7;

    // Reset state
    @(negedge clk);
    chk("rst_anode", 0, 32'(anode), 32'hF);
    chk("rst_nibble", 0, 32'(nibble), 32'h0);
    chk("rst_dp", 0, 32'(dp), 32'h0);
    chk("rst_idx", 0, 32'(idx), 32'h0);
    chk("rst_ft", 0, 32'(ft), 32'h0);
    reset_n = 1'b1;
    cyc = 0;

    // Scan timing and tear-free update
    for (int k = 1; k <= 48; k++) begin
      load = vt[k].ld; data_in = vt[k].din; dp_in = vt[k].dpi;
      step();
      load = 1'b0;
      chk("tbl_anode", k, 32'(anode), 32'(vt[k].an));
      chk("tbl_nibble", k, 32'(nibble), 32'(vt[k].nib));
      chk("tbl_dp", k, 32'(dp), 32'(vt[k].dpo));
      chk("tbl_idx", k, 32'(idx), 32'(vt[k].ix));
      chk("tbl_ft", k, 32'(ft), 32'(vt[k].ft));
    end

    // Leading-zero suppression, then lz_en off, then live blank_mask
    do_reset();
    lz_en = 1'b1; load = 1'b1; data_in = 16'h0050; dp_in = 4'b0000;
    step();
    load = 1'b0;
    run_to(24); chk("lz_ft", 24, 32'(ft), 32'h1);
    run_to(26); chk_main(26, 4'hE, 4'h0, 2'd0);
    run_to(32); chk_main(32, 4'hD, 4'h5, 2'd1);
    run_to(38); chk_main(38, 4'hF, 4'h0, 2'd2);
    run_to(44); chk_main(44, 4'hF, 4'h0, 2'd3);
    run_to(48); lz_en = 1'b0;
    run_to(50); chk_main(50, 4'hE, 4'h0, 2'd0);
    run_to(56); chk_main(56, 4'hD, 4'h5, 2'd1);
    run_to(62); chk_main(62, 4'hB, 4'h0, 2'd2);
    blank_mask = 4'b0100;                        // mid-slot: must not cut digit 2
    run_to(64); chk_main(64, 4'hB, 4'h0, 2'd2);
    run_to(68); chk_main(68, 4'h7, 4'h0, 2'd3);
    run_to(80); chk_main(80, 4'hD, 4'h5, 2'd1);
    run_to(86); chk_main(86, 4'hF, 4'h0, 2'd2);
    run_to(92); chk_main(92, 4'h7, 4'h0, 2'd3);
    blank_mask = 4'b0000;

    // Coincident load on the wrap edge
    do_reset();
    load = 1'b1; data_in = 16'hAAAA;
    step();
    load = 1'b0;
    run_to(23);
    load = 1'b1; data_in = 16'hBBBB;
    step();
    load = 1'b0;
    chk("coin_ft1", 24, 32'(ft), 32'h1);
    run_to(25); chk("coin_ft_low", 25, 32'(ft), 32'h0);
    run_to(26); chk_main(26, 4'hE, 4'hA, 2'd0);
    run_to(32); chk_main(32, 4'hD, 4'hA, 2'd1);
    run_to(48); chk("coin_ft2", 48, 32'(ft), 32'h1);
    run_to(50); chk_main(50, 4'hE, 4'hB, 2'd0);
    run_to(56); chk_main(56, 4'hD, 4'hB, 2'd1);

    // Async reset mid digit-2 slot with pending data outstanding
    run_to(55);
    load = 1'b1; data_in = 16'h9999;
    step();
    load = 1'b0;
    run_to(62); chk_main(62, 4'hB, 4'hB, 2'd2);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_anode", 62, 32'(anode), 32'hF);
    chk("arst_idx", 62, 32'(idx), 32'h0);
    chk("arst_nibble", 62, 32'(nibble), 32'h0);
    chk("arst_nd_anode", 62, 32'(an1), 32'hF);
    @(negedge clk);
    reset_n = 1'b1;
    cyc = 0;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("nodead_anode", k, 32'(an1), 32'(nd_an[(k-1)/4]));
      if (k <= 4) chk_main(k, 4'hE, 4'h0, 2'd0);
    end
    run_to(17); chk("nodead_wrap", 17, 32'(an1), 32'hE);
    run_to(5);
    run_to(24); chk("arst_no_ft", 24, 32'(ft), 32'h0);
    run_to(26); chk_main(26, 4'hE, 4'h0, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
